imu_accel_reader: RTL and testbench
===================================

Name: imu_accel_reader

Overview:
- Transaction sequencer placed directly upstream of the I2C master in the IMU top level.
- On request, or periodically, it issues six single-byte register reads: ACCX_LSB through ACCZ_MSB, i.e. BASE_REG to BASE_REG+5.
- It drives the master's start, read/write, slave address and register address inputs, and consumes the master's data byte and done flag.
- Captured bytes are assembled into three signed 16-bit samples and published atomically with a one-cycle valid strobe.

Parameters:
- IMU_ADDR, 7'h68, I2C slave address driven to the master.
- BASE_REG, 7'h12, register address of ACCX_LSB; the six reads use BASE_REG+0 .. BASE_REG+5.
- TIMEOUT_CYCLES, 50000, clk cycles allowed per byte (ISSUE+WAIT_DONE) before abort; 16-bit counter.
- AUTO_PERIOD, 0, self-trigger interval in clk cycles; 0 disables auto-trigger. 24-bit counter.

Ports:
- clk  in  1  system clock, same as the master's source clock.
- rst  in  1  asynchronous active-high reset.
- sample_req  in  1  single-cycle request to acquire one X/Y/Z sample.
- i2c_busy  in  1  master busy level.
- i2c_done  in  1  master done flag; may stay high for many clk cycles.
- i2c_data_out  in  8  byte read by the master.
- i2c_start  out  1  start request to the master.
- i2c_read_write  out  1  constant 1 (read).
- i2c_slave_addr  out  7  constant IMU_ADDR.
- i2c_reg_addr  out  7  BASE_REG + byte index.
- acc_x, acc_y, acc_z  out  16 each  last complete sample, {MSB,LSB}.
- sample_valid  out  1  one-cycle pulse when acc_* update.
- busy  out  1  high whenever state != IDLE.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst=1) puts outputs at: state IDLE, idx=0, i2c_start=0, i2c_reg_addr=BASE_REG, acc_*=0, sample_valid=0, busy=0, error=0, shadow bytes=0, done_q=0, counters=0. i2c_read_write=1 and i2c_slave_addr=IMU_ADDR at all times.
- done_rise = i2c_done & ~done_q, where done_q is i2c_done registered on clk.
- trigger = sample_req, OR auto-counter terminal count (AUTO_PERIOD!=0 and count==AUTO_PERIOD-1). The auto counter is free-running and wraps to 0 at terminal count.
- IDLE:
  - On trigger: go to ISSUE next cycle, set idx=0, clear error, clear timeout counter.
  - Triggers arriving while not IDLE are dropped, not queued.
- ISSUE:
  - Drive i2c_start=1 and i2c_reg_addr=BASE_REG+idx.
  - Hold start until i2c_busy=1 is sampled; this is required because the master runs on a divided clock.
  - Then i2c_start=0 and go to WAIT_DONE.
- WAIT_DONE: on done_rise, latch i2c_data_out into shadow[idx] and go to NEXT.
  - A done that is already high on entry does not count; only a rising edge is accepted.
- NEXT:
  - If idx==5, go to PUBLISH.
  - Otherwise idx<=idx+1 and go to ISSUE.
  - Before re-issuing, i2c_done must be low (wait in NEXT while i2c_done=1).
- PUBLISH, one cycle:
  - acc_x={shadow1,shadow0}, acc_y={shadow3,shadow2}, acc_z={shadow5,shadow4}, all updated in the same cycle.
  - sample_valid=1 for exactly this cycle; go to IDLE.
- Timeout:
  - The counter increments in ISSUE and WAIT_DONE and is cleared on each byte capture.
  - On reaching TIMEOUT_CYCLES-1: i2c_start=0, error=1, return to IDLE.
  - acc_* are not modified and there is no sample_valid pulse; the partial shadow data is discarded.
- error stays set until the next accepted trigger.
- Nominal latency: trigger to sample_valid = 6 × (master transaction time + handshake overhead) + 2 clk. No valid pulse is ever produced from a partial set of bytes.
- Simultaneous sample_req and auto terminal count in IDLE are treated as one trigger.
- Reset mid-transaction: immediate return to IDLE with i2c_start=0. acc_* are cleared to 0.

Test Plan:
- Basic read:
  - Stimulus: after reset, pulse sample_req. A master model returns bytes 0x11,0x22,0x33,0x44,0x55,0x66 for reg 0x12..0x17.
  - Required: six start handshakes with i2c_reg_addr 0x12..0x17 in order; acc_x=0x2211, acc_y=0x4433, acc_z=0x6655; sample_valid high for exactly 1 cycle; busy low afterwards.
- Slow master:
  - Stimulus: busy rises 300 clk after start; done is held high 500 clk.
  - Required: i2c_start stays high until busy is seen; each byte is captured once; no double capture while done is held.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; master never asserts done on byte 3.
  - Required: error=1 at cycle 100 of that byte; state IDLE; acc_* keep their previous values; no sample_valid.
  - Then pulse sample_req: error clears the next cycle and a normal sample completes.
- Dropped request: a sample_req pulse mid-transaction produces exactly one sample_valid, not two.
- Auto trigger: AUTO_PERIOD=20000, fast master model; sample_valid pulses are spaced 20000 clk apart; the sample_req port is unused.
- Reset mid-operation: assert rst during byte 4; i2c_start=0, busy=0, acc_*=0 immediately (asynchronously); the next request completes normally.

Source files
------------

// File: rtl/imu_accel_reader.sv
// Sequences six single-byte accelerometer register reads through an I2C master
// and publishes the assembled signed X/Y/Z sample with a one-cycle valid strobe.
module imu_accel_reader #(
    parameter logic [6:0]  IMU_ADDR       = 7'h68,
    parameter logic [6:0]  BASE_REG       = 7'h12,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned AUTO_PERIOD    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_req,
    input  logic        i2c_busy,
    input  logic        i2c_done,
    input  logic [7:0]  i2c_data_out,
    output logic        i2c_start,
    output logic        i2c_read_write,
    output logic [6:0]  i2c_slave_addr,
    output logic [6:0]  i2c_reg_addr,
    output logic [15:0] acc_x,
    output logic [15:0] acc_y,
    output logic [15:0] acc_z,
    output logic        sample_valid,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, NEXT, PUBLISH} state_t;

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0] AUTO_LAST = 24'((AUTO_PERIOD == 0) ? 0 : AUTO_PERIOD - 1);
    localparam logic [2:0]  LAST_IDX  = 3'd5;

    state_t      state_q, state_d;
    logic [2:0]  idx_q;
    logic [7:0]  shadow_q [6];
    logic        done_q;
    logic [15:0] tmo_cnt_q;
    logic [23:0] auto_cnt_q;
    logic        auto_tc, trigger, done_rise, tmo_hit, capture, timeout;

    assign auto_tc   = (AUTO_PERIOD != 0) && (auto_cnt_q == AUTO_LAST);
    assign trigger   = sample_req | auto_tc;
    assign done_rise = i2c_done & ~done_q;
    assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger) state_d = ISSUE;
            end
            // Start is held until the slow-clocked master reports busy.
            ISSUE: begin
                if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else if (i2c_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    capture = 1'b1;
                    state_d = NEXT;
                end else if (tmo_hit) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            // A lingering done from the previous byte must clear before re-issuing.
            NEXT: begin
                if (idx_q == LAST_IDX) state_d = PUBLISH;
                else if (!i2c_done) state_d = ISSUE;
            end
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign i2c_start      = (state_q == ISSUE) && !tmo_hit;
    assign i2c_read_write = 1'b1;
    assign i2c_slave_addr = IMU_ADDR;
    assign i2c_reg_addr   = BASE_REG + {4'b0000, idx_q};
    assign busy           = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            done_q       <= 1'b0;
            tmo_cnt_q    <= '0;
            auto_cnt_q   <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            sample_valid <= 1'b0;
            error        <= 1'b0;
            for (int i = 0; i < 6; i++) shadow_q[i] <= '0;
        end else begin
            done_q       <= i2c_done;
            sample_valid <= 1'b0;
            if (AUTO_PERIOD != 0) auto_cnt_q <= auto_tc ? '0 : auto_cnt_q + 24'd1;
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        idx_q     <= '0;
                        error     <= 1'b0;
                        tmo_cnt_q <= '0;
                    end
                end
                ISSUE, WAIT_DONE: begin
                    if (capture)      tmo_cnt_q <= '0;
                    else if (timeout) error     <= 1'b1;
                    else              tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    for (int i = 0; i < 6; i++) begin
                        if (capture && idx_q == 3'(i)) shadow_q[i] <= i2c_data_out;
                    end
                end
                NEXT: begin
                    if (state_d == ISSUE) idx_q <= idx_q + 3'd1;
                end
                // All three axes and the strobe change on the same edge.
                PUBLISH: begin
                    acc_x        <= {shadow_q[1], shadow_q[0]};
                    acc_y        <= {shadow_q[3], shadow_q[2]};
                    acc_z        <= {shadow_q[5], shadow_q[4]};
                    sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imu_accel_reader.sv
// Bench for imu_accel_reader: nominal, short-timeout and auto-trigger instances,
// each served by a cycle-stepped I2C master model.
module tb_imu_accel_reader;
    localparam logic [6:0] BASE = 7'h12;
    localparam logic [6:0] ADDR = 7'h68;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_v, req, m_busy, m_done;
    logic [7:0]  m_data [3];
    wire  [2:0]  m_start, m_rw, m_valid, m_bsy, m_err;
    wire  [6:0]  m_sa  [3];
    wire  [6:0]  m_reg [3];
    wire  [15:0] ax [3];
    wire  [15:0] ay [3];
    wire  [15:0] az [3];

    imu_accel_reader #(.IMU_ADDR(ADDR), .BASE_REG(BASE), .TIMEOUT_CYCLES(50000), .AUTO_PERIOD(0)) u_nom (
        .clk(clk), .rst(rst_v[0]), .sample_req(req[0]), .i2c_busy(m_busy[0]), .i2c_done(m_done[0]),
        .i2c_data_out(m_data[0]), .i2c_start(m_start[0]), .i2c_read_write(m_rw[0]),
        .i2c_slave_addr(m_sa[0]), .i2c_reg_addr(m_reg[0]), .acc_x(ax[0]), .acc_y(ay[0]), .acc_z(az[0]),
        .sample_valid(m_valid[0]), .busy(m_bsy[0]), .error(m_err[0]));

    imu_accel_reader #(.IMU_ADDR(ADDR), .BASE_REG(BASE), .TIMEOUT_CYCLES(100), .AUTO_PERIOD(0)) u_tmo (
        .clk(clk), .rst(rst_v[1]), .sample_req(req[1]), .i2c_busy(m_busy[1]), .i2c_done(m_done[1]),
        .i2c_data_out(m_data[1]), .i2c_start(m_start[1]), .i2c_read_write(m_rw[1]),
        .i2c_slave_addr(m_sa[1]), .i2c_reg_addr(m_reg[1]), .acc_x(ax[1]), .acc_y(ay[1]), .acc_z(az[1]),
        .sample_valid(m_valid[1]), .busy(m_bsy[1]), .error(m_err[1]));

    imu_accel_reader #(.IMU_ADDR(ADDR), .BASE_REG(BASE), .TIMEOUT_CYCLES(50000), .AUTO_PERIOD(20000)) u_auto (
        .clk(clk), .rst(rst_v[2]), .sample_req(req[2]), .i2c_busy(m_busy[2]), .i2c_done(m_done[2]),
        .i2c_data_out(m_data[2]), .i2c_start(m_start[2]), .i2c_read_write(m_rw[2]),
        .i2c_slave_addr(m_sa[2]), .i2c_reg_addr(m_reg[2]), .acc_x(ax[2]), .acc_y(ay[2]), .acc_z(az[2]),
        .sample_valid(m_valid[2]), .busy(m_bsy[2]), .error(m_err[2]));

    typedef struct {
        logic [5:0][7:0] b;
        int              bdelay;
        int              xfer;
        int              hold;
        logic [15:0]     ex;
        logic [15:0]     ey;
        logic [15:0]     ez;
    } vec_t;

    int          m_phase [3];
    int          m_cnt   [3];
    int          m_cur   [3];
    int          cfg_delay [3];
    int          cfg_xfer  [3];
    int          cfg_hold  [3];
    int          cfg_drop  [3];
    logic [7:0]  mem [3][6];
    logic [6:0]  addr_log [$];
    logic [47:0] exp_q [$];
    logic [47:0] auto_exp;
    int          auto_t [$];
    int          valid_cnt [3];
    logic        prev_valid [3];
    int          start_errs = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t rand_vec(input int d, input int x, input int h);
        vec_t v;
        for (int i = 0; i < 6; i++) v.b[i] = 8'($urandom);
        v.bdelay = d;
        v.xfer   = x;
        v.hold   = h;
        v.ex     = {v.b[1], v.b[0]};
        v.ey     = {v.b[3], v.b[2]};
        v.ez     = {v.b[5], v.b[4]};
        return v;
    endfunction

    // Master model: busy rises cfg_delay cycles after start, lasts cfg_xfer,
    // then done is held cfg_hold cycles with the addressed byte (none for cfg_drop).
    task automatic master_step(input int k);
        if (rst_v[k]) begin
            m_phase[k] = 0;
            m_busy[k]  = 1'b0;
            m_done[k]  = 1'b0;
            return;
        end
        case (m_phase[k])
            0: if (m_start[k]) begin
                if (k == 0) addr_log.push_back(m_reg[k]);
                m_cur[k]   = int'(m_reg[k]) - int'(BASE);
                m_cnt[k]   = cfg_delay[k];
                m_phase[k] = 1;
            end
            1: if (m_cnt[k] == 0) begin
                m_busy[k]  = 1'b1;
                m_cnt[k]   = cfg_xfer[k];
                m_phase[k] = 2;
            end else begin
                if (!m_start[k]) start_errs++;
                m_cnt[k]--;
            end
            2: begin
                if (m_cnt[k] < cfg_xfer[k] && m_start[k]) start_errs++;
                if (m_cnt[k] == 0) begin
                    m_busy[k] = 1'b0;
                    if (m_cur[k] == cfg_drop[k]) begin
                        m_phase[k] = 0;
                    end else begin
                        if (m_cur[k] >= 0 && m_cur[k] < 6) m_data[k] = mem[k][m_cur[k]];
                        else m_data[k] = 8'hEE;
                        m_done[k]  = 1'b1;
                        m_cnt[k]   = cfg_hold[k];
                        m_phase[k] = 3;
                    end
                end else begin
                    m_cnt[k]--;
                end
            end
            default: begin
                if (m_start[k]) start_errs++;
                if (m_cnt[k] == 0) begin
                    m_done[k]  = 1'b0;
                    m_phase[k] = 0;
                end else begin
                    m_cnt[k]--;
                end
            end
        endcase
    endtask

    task automatic mon_step(input int k);
        if (m_valid[k]) begin
            check("valid_width", prev_valid[k], 0);
            valid_cnt[k]++;
            if (k == 2) begin
                auto_t.push_back(cyc);
                check("auto_acc", {ax[2], ay[2], az[2]}, auto_exp);
            end else if (exp_q.size() == 0) begin
                check("unexpected_valid", m_valid[k], 0);
            end else begin
                check("acc_xyz", {ax[k], ay[k], az[k]}, exp_q.pop_front());
            end
        end
        prev_valid[k] = m_valid[k];
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 3; k++) begin
                master_step(k);
                mon_step(k);
            end
        end
    end

    task automatic setup(input int k, input vec_t v, input int drop);
        cfg_delay[k] = v.bdelay;
        cfg_xfer[k]  = v.xfer;
        cfg_hold[k]  = v.hold;
        cfg_drop[k]  = drop;
        for (int i = 0; i < 6; i++) mem[k][i] = v.b[i];
    endtask

    task automatic wait_idle(input int k);
        int guard = 0;
        while ((m_phase[k] != 0 || m_bsy[k]) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", (guard < 5000), 1);
    endtask

    task automatic pulse_req(input int k);
        req[k] = 1'b1;
        @(negedge clk);
        req[k] = 1'b0;
    endtask

    task automatic do_sample(input int k, input vec_t v, input bit chk_clear);
        int guard;
        int vc;
        wait_idle(k);
        setup(k, v, -1);
        addr_log.delete();
        exp_q.push_back({v.ex, v.ey, v.ez});
        vc = valid_cnt[k];
        req[k] = 1'b1;
        @(negedge clk);
        if (chk_clear) begin
            check("err_clear", m_err[k], 0);
            check("busy_after_req", m_bsy[k], 1);
        end
        req[k] = 1'b0;
        guard = 0;
        while (valid_cnt[k] == vc && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("sample_arrived", (guard < 20000), 1);
        if (guard >= 20000) exp_q.delete();
        @(negedge clk);
        check("valid_one_cycle", m_valid[k], 0);
        check("idle_after", m_bsy[k], 0);
        check("no_error", m_err[k], 0);
        if (k == 0) begin
            check("start_count", addr_log.size(), 6);
            for (int i = 0; i < 6 && i < addr_log.size(); i++) check("reg_order", addr_log[i], BASE + 7'(i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          guard;
        int          vc;
        logic [47:0] prev;
        vec_t        v;

        rst_v  = 3'b111;
        req    = 3'b000;
        m_busy = 3'b000;
        m_done = 3'b000;
        for (int k = 0; k < 3; k++) begin
            m_data[k]     = 8'h00;
            m_phase[k]    = 0;
            m_cnt[k]      = 0;
            m_cur[k]      = 0;
            valid_cnt[k]  = 0;
            prev_valid[k] = 1'b0;
            cfg_delay[k]  = 0;
            cfg_xfer[k]   = 3;
            cfg_hold[k]   = 1;
            cfg_drop[k]   = -1;
            for (int i = 0; i < 6; i++) mem[k][i] = 8'($urandom);
        end
        auto_exp = {mem[2][1], mem[2][0], mem[2][3], mem[2][2], mem[2][5], mem[2][4]};

        tbl[0].b      = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        tbl[0].bdelay = 0;
        tbl[0].xfer   = 3;
        tbl[0].hold   = 1;
        tbl[0].ex     = 16'h2211;
        tbl[0].ey     = 16'h4433;
        tbl[0].ez     = 16'h6655;
        tbl[1]        = rand_vec(300, 10, 500);
        for (int i = 2; i < 6; i++)
            tbl[i] = rand_vec($urandom_range(0, 6), $urandom_range(1, 12), $urandom_range(1, 8));

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_start", m_start[k], 0);
            check("rst_rw", m_rw[k], 1);
            check("rst_slave", m_sa[k], ADDR);
            check("rst_reg", m_reg[k], BASE);
            check("rst_acc", {ax[k], ay[k], az[k]}, 48'd0);
            check("rst_valid", m_valid[k], 0);
            check("rst_busy", m_bsy[k], 0);
            check("rst_error", m_err[k], 0);
        end
        rst_v = 3'b000;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_sample(0, tbl[i], 1'b0);
        check("start_handshake_slow", start_errs, 0);

        // Second request mid-transaction must be dropped.
        wait_idle(0);
        v = rand_vec(4, 15, 2);
        setup(0, v, -1);
        addr_log.delete();
        exp_q.push_back({v.ex, v.ey, v.ez});
        vc = valid_cnt[0];
        pulse_req(0);
        guard = 0;
        while (addr_log.size() < 3 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        pulse_req(0);
        guard = 0;
        while (valid_cnt[0] == vc && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        repeat (300) @(negedge clk);
        check("single_valid", valid_cnt[0] - vc, 1);
        check("drop_idle", m_bsy[0], 0);
        check("drop_rw", m_rw[0], 1);
        check("drop_slave", m_sa[0], ADDR);

        // Asynchronous reset while byte 4 is in flight.
        wait_idle(0);
        v = rand_vec(5, 20, 3);
        setup(0, v, -1);
        addr_log.delete();
        pulse_req(0);
        guard = 0;
        while (addr_log.size() < 5 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reached_byte4", (guard < 5000), 1);
        #2;
        rst_v[0] = 1'b1;
        #1;
        check("midrst_start", m_start[0], 0);
        check("midrst_busy", m_bsy[0], 0);
        check("midrst_acc", {ax[0], ay[0], az[0]}, 48'd0);
        check("midrst_valid", m_valid[0], 0);
        check("midrst_reg", m_reg[0], BASE);
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0;
        do_sample(0, rand_vec(1, 6, 2), 1'b0);

        // Timeout on byte 3 with a 100-cycle budget.
        v = rand_vec(2, 8, 2);
        prev = {v.ex, v.ey, v.ez};
        do_sample(1, v, 1'b0);
        wait_idle(1);
        setup(1, rand_vec(2, 5, 1), 3);
        vc = valid_cnt[1];
        pulse_req(1);
        guard = 0;
        while (!(m_start[1] && m_reg[1] == BASE + 7'd3) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("tmo_byte3_issued", (guard < 2000), 1);
        repeat (99) @(negedge clk);
        check("tmo_not_early", m_err[1], 0);
        @(negedge clk);
        check("tmo_error", m_err[1], 1);
        check("tmo_idle", m_bsy[1], 0);
        check("tmo_start_low", m_start[1], 0);
        check("tmo_acc_kept", {ax[1], ay[1], az[1]}, prev);
        repeat (20) @(negedge clk);
        check("tmo_no_valid", valid_cnt[1] - vc, 0);
        check("error_sticky", m_err[1], 1);
        do_sample(1, rand_vec(1, 4, 1), 1'b1);

        // Auto-trigger instance has been running since reset release.
        guard = 0;
        while (auto_t.size() < 3 && guard < 80000) begin
            @(negedge clk);
            guard++;
        end
        check("auto_pulses", (auto_t.size() >= 3), 1);
        if (auto_t.size() >= 3) begin
            check("auto_gap1", auto_t[1] - auto_t[0], 20000);
            check("auto_gap2", auto_t[2] - auto_t[1], 20000);
        end
        check("auto_no_error", m_err[2], 0);
        check("start_handshake", start_errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
